// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues credit-limited word requests to
// instruction memory, tracks in-flight PCs and queues returned words for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        InstrValidD,
  input  logic        InstrReadyD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned SW  = CW + 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] pc_q, pc_d;
  ptr_t        q_head_q, q_head_d;
  ptr_t        q_tail_q, q_tail_d;
  cnt_t        count_q, count_d;
  ptr_t        if_head_q, if_head_d;
  ptr_t        if_tail_q, if_tail_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        discard_q, discard_d;

  logic [31:0] q_pc_mem    [DEPTH];
  logic [31:0] q_instr_mem [DEPTH];
  logic [31:0] if_pc_mem   [DEPTH];

  logic [SW-1:0] credits_used;
  logic          accept;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          q_push;
  logic          q_pop;

  // Every queued word, outstanding request and pending discard holds one credit.
  assign credits_used   = SW'(count_q) + SW'(outstanding_q) + SW'(discard_q);
  assign imem_req_valid = !rst && !Redirect && (credits_used < SW'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (discard_q != '0);
  assign rsp_keep = imem_rsp_valid && (discard_q == '0);
  assign q_push   = rsp_keep && !Redirect;
  assign q_pop    = InstrValidD && InstrReadyD && !Redirect;

  assign InstrValidD = (count_q != '0);
  assign InstrD      = InstrValidD ? q_instr_mem[q_head_q] : NOP;
  assign PCD         = InstrValidD ? q_pc_mem[q_head_q]    : 32'h0000_0000;

  always_comb begin
    // NOTE: every _d starts from its hold value so no branch can infer a latch.
    pc_d          = pc_q;
    q_head_d      = q_head_q;
    q_tail_d      = q_tail_q;
    count_d       = count_q;
    if_head_d     = if_head_q;
    if_tail_d     = if_tail_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (Redirect) begin
      // A response landing this cycle retires one credit whether it was
      // already marked for discard or would have been queued.
      pc_d          = RedirectPC & 32'hFFFF_FFFC;
      q_head_d      = '0;
      q_tail_d      = '0;
      count_d       = '0;
      if_head_d     = '0;
      if_tail_d     = '0;
      outstanding_d = '0;
      discard_d     = discard_q + outstanding_q - cnt_t'(imem_rsp_valid);
    end else begin
      if (accept) begin
        pc_d      = pc_q + 32'd4;
        if_tail_d = if_tail_q + ptr_t'(1);
      end
      if (rsp_drop) begin
        discard_d = discard_q - cnt_t'(1);
      end
      if (rsp_keep) begin
        if_head_d = if_head_q + ptr_t'(1);
        q_tail_d  = q_tail_q + ptr_t'(1);
      end
      if (q_pop) begin
        q_head_d = q_head_q + ptr_t'(1);
      end
      outstanding_d = outstanding_q + cnt_t'(accept) - cnt_t'(rsp_keep);
      count_d       = count_q + cnt_t'(q_push) - cnt_t'(q_pop);
    end
  end

  // NOTE: sequential state is assigned with <= only; the = assignments above
  // belong to combinational next-state logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      q_head_q      <= '0;
      q_tail_q      <= '0;
      count_q       <= '0;
      if_head_q     <= '0;
      if_tail_q     <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      q_head_q      <= q_head_d;
      q_tail_q      <= q_tail_d;
      count_q       <= count_d;
      if_head_q     <= if_head_d;
      if_tail_q     <= if_tail_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // NOTE: storage arrays carry no reset; counts and pointers qualify every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      if_pc_mem[if_tail_q] <= pc_q;
    end
    if (q_push) begin
      q_pc_mem[q_tail_q]    <= if_pc_mem[if_head_q];
      q_instr_mem[q_tail_q] <= imem_rsp_data;
    end
  end

  a_no_queue_overflow : assert property (
    @(posedge clk) disable iff (rst) !(q_push && (count_q == cnt_t'(DEPTH))));

  a_no_unexpected_rsp : assert property (
    @(posedge clk) disable iff (rst)
      !(imem_rsp_valid && (outstanding_q == '0) && (discard_q == '0)));

endmodule
